logic_instruction_sequencer: RTL and testbench

//  Front end that drives the combinational logical unit of the 8-bit CPU: accepts instruction

---
 rtl/logic_instruction_sequencer.sv | 136 +++++++++++++
 tb/tb_logic_instruction_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_instruction_sequencer.sv
// Instruction front end for the 8-bit CPU logical unit.
// Accepts instruction bytes over valid/ready, decodes them into logical-unit
// opcodes, supplies operands from a 4-entry register file, and writes the
// combinational luResult back into the destination register.
module logic_instruction_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter bit STRICT_ILLEGAL = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instrValid,
    output logic                  instrReady,
    input  logic [7:0]            instrData,
    output logic [2:0]            luOpcode,
    output logic [DATA_WIDTH-1:0] luOperandA,
    output logic [DATA_WIDTH-1:0] luOperandB,
    input  logic [DATA_WIDTH-1:0] luResult,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic [1:0]            dbgSel,
    output logic [DATA_WIDTH-1:0] dbgData
);

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        IMM       = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            dst_q, dst_d;
    logic [DATA_WIDTH-1:0] regs_q [4];
    logic [DATA_WIDTH-1:0] regs_d [4];
    logic [2:0]            luOpcode_q, luOpcode_d;
    logic [DATA_WIDTH-1:0] opA_q, opA_d;
    logic [DATA_WIDTH-1:0] opB_q, opB_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  xfer;

    // Ready only in the two byte-consuming states; held low while reset is asserted.
    assign instrReady = ~reset & ((state_q == FETCH) | (state_q == IMM));
    assign xfer       = instrValid & instrReady;
    assign busy       = (state_q != FETCH);
    assign done       = done_q;
    assign error      = error_q;
    assign luOpcode   = luOpcode_q;
    assign luOperandA = opA_q;
    assign luOperandB = opB_q;
    assign dbgData    = regs_q[dbgSel];

    // Next-state, decode, operand capture and register-file writeback.
    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        regs_d     = regs_q;
        luOpcode_d = luOpcode_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        done_d     = 1'b0;
        error_d    = error_q;
        case (state_q)
            FETCH: begin
                if (xfer) begin
                    case (instrData[7:5])
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            // Operands are sampled on entry to EXECUTE and then held
                            // through WRITEBACK so luResult stays stable.
                            state_d    = EXECUTE;
                            dst_d      = instrData[3:2];
                            luOpcode_d = {1'b0, instrData[6:5]};
                            opA_d      = regs_q[instrData[3:2]];
                            opB_d      = regs_q[instrData[1:0]];
                        end
                        3'b100: begin
                            state_d = IMM;
                            dst_d   = instrData[3:2];
                        end
                        3'b111: begin
                            error_d = 1'b0;
                        end
                        default: begin
                            if (STRICT_ILLEGAL) begin
                                error_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            IMM: begin
                if (xfer) begin
                    regs_d[dst_q] = DATA_WIDTH'(instrData);
                    done_d        = 1'b1;
                    state_d       = FETCH;
                end
            end
            EXECUTE: begin
                state_d = WRITEBACK;
            end
            WRITEBACK: begin
                regs_d[dst_q] = luResult;
                done_d        = 1'b1;
                state_d       = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            dst_q      <= 2'd0;
            regs_q     <= '{default: '0};
            luOpcode_q <= 3'd0;
            opA_q      <= '0;
            opB_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            regs_q     <= regs_d;
            luOpcode_q <= luOpcode_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_logic_instruction_sequencer.sv
// Bench for logic_instruction_sequencer: instruction-level reference model,
// per-cycle output comparison, and directed instruction sequences.
module tb_logic_instruction_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       instrValid;
    logic [7:0] instrData;
    logic [1:0] dbgSel;

    logic       instrReady, busy, done, error;
    logic [2:0] luOpcode;
    logic [7:0] luOperandA, luOperandB, luResult, dbgData;

    logic       instrReady2, busy2, done2, error2;
    logic [2:0] luOpcode2;
    logic [7:0] luOperandA2, luOperandB2, luResult2, dbgData2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic logic [7:0] lu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign luResult  = lu_f(luOpcode, luOperandA, luOperandB);
    assign luResult2 = lu_f(luOpcode2, luOperandA2, luOperandB2);

    logic_instruction_sequencer #(.DATA_WIDTH(8), .STRICT_ILLEGAL(1'b1)) dut (
        .clock(clock), .reset(reset), .instrValid(instrValid), .instrReady(instrReady),
        .instrData(instrData), .luOpcode(luOpcode), .luOperandA(luOperandA),
        .luOperandB(luOperandB), .luResult(luResult), .busy(busy), .done(done),
        .error(error), .dbgSel(dbgSel), .dbgData(dbgData)
    );

    logic_instruction_sequencer #(.DATA_WIDTH(8), .STRICT_ILLEGAL(1'b0)) dut_lax (
        .clock(clock), .reset(reset), .instrValid(instrValid), .instrReady(instrReady2),
        .instrData(instrData), .luOpcode(luOpcode2), .luOperandA(luOperandA2),
        .luOperandB(luOperandB2), .luResult(luResult2), .busy(busy2), .done(done2),
        .error(error2), .dbgSel(dbgSel), .dbgData(dbgData2)
    );

    // Instruction-level model: an op in flight counts down to its writeback,
    // a pending LOADI consumes the next byte, otherwise a byte is decoded.
    logic [7:0] m_regs [4];
    logic [7:0] m_a, m_b;
    logic [2:0] m_opc;
    logic [1:0] m_dst;
    int         m_cnt;
    bit         m_imm, m_done, m_err;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            m_a = 8'h00; m_b = 8'h00; m_opc = 3'd0; m_dst = 2'd0;
            m_cnt = 0; m_imm = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_regs[m_dst] = lu_f(m_opc, m_a, m_b);
                    m_done = 1'b1;
                end
            end else if (instrValid) begin
                if (m_imm) begin
                    m_regs[m_dst] = instrData;
                    m_imm  = 1'b0;
                    m_done = 1'b1;
                end else if (instrData[7:5] < 3'd4) begin
                    m_opc = instrData[7:5];
                    m_dst = instrData[3:2];
                    m_a   = m_regs[instrData[3:2]];
                    m_b   = m_regs[instrData[1:0]];
                    m_cnt = 2;
                end else if (instrData[7:5] == 3'd4) begin
                    m_imm = 1'b1;
                    m_dst = instrData[3:2];
                end else if (instrData[7:5] == 3'd7) begin
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            cmp("instrReady", instrReady, 32'(!reset && m_cnt == 0));
            cmp("busy", busy, 32'(m_cnt != 0 || m_imm));
            cmp("done", done, 32'(m_done));
            cmp("error", error, 32'(m_err));
            cmp("luOpcode", luOpcode, m_opc);
            cmp("luOperandA", luOperandA, m_a);
            cmp("luOperandB", luOperandB, m_b);
            cmp("dbgData", dbgData, m_regs[dbgSel]);
            cmp("lax_error", error2, 0);
            cmp("lax_done", done2, 32'(m_done));
            cmp("lax_dbgData", dbgData2, m_regs[dbgSel]);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        dbgSel = dbgSel + 2'd1;
    endtask

    task automatic send_acc(input logic [7:0] b, output int acc);
        bit ok;
        ok = 1'b0;
        instrValid = 1'b1;
        instrData  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (instrReady) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        acc = cyc;
        instrValid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: byte 0x%0h never accepted, ready stayed 0", b);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int acc;
        send_acc(b, acc);
    endtask

    task automatic check_reg(input int idx, input logic [7:0] exp, input string nm);
        dbgSel = 2'(idx);
        @(negedge clock);
        cmp(nm, dbgData, exp);
        cmp({nm, "_model"}, m_regs[idx], exp);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        reset = 1'b1; instrValid = 1'b0; instrData = 8'h00; dbgSel = 2'd0;
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;
        @(negedge clock);
        cmp("rst_busy", busy, 0);
        cmp("rst_luOpcode", luOpcode, 0);
        step();
        reset = 1'b0;

        // LOADI R0=0x0F, R1=0x55; AND R0,R1
        send(8'h80); send(8'h0F);
        @(negedge clock); cmp("loadi_done", done, 1); step();
        send(8'h84); send(8'h55);
        send(8'h01);
        @(negedge clock);
        cmp("and_exec_op", luOpcode, 3'b000);
        cmp("and_exec_a", luOperandA, 8'h0F);
        cmp("and_exec_b", luOperandB, 8'h55);
        step();
        @(negedge clock); cmp("and_done_early", done, 0); step();
        dbgSel = 2'd0;
        @(negedge clock);
        cmp("and_done_n3", done, 1);
        cmp("and_r0", dbgData, 8'h05);
        step();

        // NAND / OR / NOR on R2 with R3
        send(8'h88); send(8'hFF); send(8'h8C); send(8'h55);
        send(8'h4B); step(); step(); check_reg(2, 8'hAA, "nand_r2");
        send(8'h88); send(8'h00);
        send(8'h2B); step(); step(); check_reg(2, 8'h55, "or_r2");
        send(8'h6B); step(); step(); check_reg(2, 8'hAA, "nor_r2");

        // Reset mid-run clears every register
        reset = 1'b1;
        for (int i = 0; i < 4; i++) check_reg(i, 8'h00, "rst_reg");
        reset = 1'b0;

        // Illegal opcodes and NOP
        send(8'h80); send(8'h3C); step();
        send(8'hA0);
        @(negedge clock);
        cmp("illegal_err", error, 1);
        cmp("illegal_lax_err", error2, 0);
        cmp("illegal_no_done", done, 0);
        step();
        check_reg(0, 8'h3C, "illegal_r0");
        send(8'hC0);
        @(negedge clock); cmp("illegal2_err", error, 1); step();
        send(8'hE0);
        @(negedge clock); cmp("nop_err", error, 0); step();

        // Backpressure while waiting for an immediate
        send(8'h84);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            cmp("imm_wait_busy", busy, 1);
            cmp("imm_wait_ready", instrReady, 1);
            step();
        end
        check_reg(1, 8'h00, "imm_wait_r1");
        send(8'h99);
        check_reg(1, 8'h99, "imm_r1");

        // Reset during EXECUTE aborts the writeback
        send(8'h01);
        reset = 1'b1;
        @(negedge clock); cmp("abort_busy", busy, 0); step();
        reset = 1'b0;
        @(negedge clock); cmp("abort_no_done1", done, 0); step();
        @(negedge clock); cmp("abort_no_done2", done, 0); step();
        check_reg(0, 8'h00, "abort_r0");

        // dst==src and back-to-back issue
        send(8'h84); send(8'h0F);
        send_acc(8'h45, a1);
        send_acc(8'h25, a2);
        cmp("b2b_gap", a2 - a1, 3);
        @(negedge clock);
        cmp("or_same_a", luOperandA, 8'hF0);
        cmp("or_same_b", luOperandB, 8'hF0);
        step(); step();
        check_reg(1, 8'hF0, "or_same_r1");

        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
